// File: rtl/alu_cmd_sequencer.sv
// Queues tagged ALU commands and issues them one at a time; response valid ALU_LAT+2 edges after an idle accept.
// cmd_ready drops only on a full FIFO (no same-cycle pop credit); rsp_* hold stable until rsp_ready.
module alu_cmd_sequencer #(
    parameter int ALU_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_opn,
    input  logic [1:0] cmd_tag,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opn,
    input  logic [3:0] alu_out0,
    input  logic [3:0] alu_out1,
    input  logic [3:0] alu_status,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_out0,
    output logic [3:0] rsp_out1,
    output logic [3:0] rsp_status,
    output logic [1:0] rsp_tag,
    output logic       busy,
    output logic [7:0] ops_done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] opn;
        logic [1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    cmd_t            mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    state_t          state_q, state_d;
    logic [LW-1:0]   wcnt_q, wcnt_d;
    logic [3:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]      alu_opn_q, alu_opn_d;
    logic [1:0]      tag_q, tag_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [3:0]      rsp_out0_q, rsp_out0_d, rsp_out1_q, rsp_out1_d, rsp_status_q, rsp_status_d;
    logic [1:0]      rsp_tag_q, rsp_tag_d;
    logic [7:0]      ops_q, ops_d;
    logic            push, pop;
    cmd_t            cmd_in, head;

    assign cmd_ready = (count_q < CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign cmd_in    = '{a: cmd_a, b: cmd_b, opn: cmd_opn, tag: cmd_tag};
    assign head      = mem_q[rd_ptr_q];

    // Storage has no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opn_d    = alu_opn_q;
        tag_d        = tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_out0_d   = rsp_out0_q;
        rsp_out1_d   = rsp_out1_q;
        rsp_status_d = rsp_status_q;
        rsp_tag_d    = rsp_tag_q;
        ops_d        = ops_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    alu_a_d   = head.a;
                    alu_b_d   = head.b;
                    alu_opn_d = head.opn;
                    tag_d     = head.tag;
                    wcnt_d    = LW'(ALU_LAT);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // wcnt counts down from ALU_LAT, so WAIT spans ALU_LAT+1 cycles.
                if (wcnt_q == '0) begin
                    rsp_out0_d   = alu_out0;
                    rsp_out1_d   = alu_out1;
                    rsp_status_d = alu_status;
                    rsp_tag_d    = tag_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    wcnt_d = wcnt_q - LW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_d       = ops_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opn_q    <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_out0_q   <= '0;
            rsp_out1_q   <= '0;
            rsp_status_q <= '0;
            rsp_tag_q    <= '0;
            ops_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opn_q    <= alu_opn_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_out0_q   <= rsp_out0_d;
            rsp_out1_q   <= rsp_out1_d;
            rsp_status_q <= rsp_status_d;
            rsp_tag_q    <= rsp_tag_d;
            ops_q        <= ops_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opn    = alu_opn_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_out0   = rsp_out0_q;
    assign rsp_out1   = rsp_out1_q;
    assign rsp_status = rsp_status_q;
    assign rsp_tag    = rsp_tag_q;
    assign ops_done   = ops_q;
    assign busy       = (count_q != '0) || (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: ALU_LAT=1 instance with a registered ALU model,
// plus an ALU_LAT=0 instance with a combinational ALU model.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_opn;
    logic [1:0] cmd_tag;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_opn;
    logic [3:0] alu_out0, alu_out1, alu_status;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_out0, rsp_out1, rsp_status;
    logic [1:0] rsp_tag;
    logic       busy;
    logic [7:0] ops_done;

    logic       z_cmd_valid, z_cmd_ready;
    logic [3:0] z_cmd_a, z_cmd_b;
    logic [2:0] z_cmd_opn;
    logic [1:0] z_cmd_tag;
    logic [3:0] z_alu_a, z_alu_b;
    logic [2:0] z_alu_opn;
    logic [3:0] z_alu_out0, z_alu_out1, z_alu_status;
    logic       z_rsp_valid, z_rsp_ready;
    logic [3:0] z_rsp_out0, z_rsp_out1, z_rsp_status;
    logic [1:0] z_rsp_tag;
    logic       z_busy;
    logic [7:0] z_ops_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [13:0] log_q[$];

    always #5 clk = ~clk;

    // Bench ALU: op0 add, op1 sub, op2 and/or, op3 multiply, others xor/not.
    function automatic logic [11:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] s;
        logic [7:0] p;
        logic [3:0] o0, o1;
        s = '0; p = '0; o0 = '0; o1 = '0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; o0 = s[3:0]; o1 = {3'b000, s[4]}; end
            3'd1: begin o0 = a - b; o1 = {3'b000, (a < b)}; end
            3'd2: begin o0 = a & b; o1 = a | b; end
            3'd3: begin p = {4'h0, a} * {4'h0, b}; o0 = p[3:0]; o1 = p[7:4]; end
            default: begin o0 = a ^ b; o1 = ~a; end
        endcase
        return {o0, o1, (o0 == 4'h0), (o1 != 4'h0), op[1:0]};
    endfunction

    always @(posedge clk) {alu_out0, alu_out1, alu_status} <= alu_f(alu_a, alu_b, alu_opn);
    assign {z_alu_out0, z_alu_out1, z_alu_status} = alu_f(z_alu_a, z_alu_b, z_alu_opn);

    always @(negedge clk)
        if (rsp_valid && rsp_ready) log_q.push_back({rsp_tag, rsp_out0, rsp_out1, rsp_status});

    alu_cmd_sequencer #(.ALU_LAT(1), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opn(cmd_opn), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opn(alu_opn),
        .alu_out0(alu_out0), .alu_out1(alu_out1), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out0(rsp_out0), .rsp_out1(rsp_out1),
        .rsp_status(rsp_status), .rsp_tag(rsp_tag), .busy(busy), .ops_done(ops_done)
    );

    alu_cmd_sequencer #(.ALU_LAT(0), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready),
        .cmd_a(z_cmd_a), .cmd_b(z_cmd_b), .cmd_opn(z_cmd_opn), .cmd_tag(z_cmd_tag),
        .alu_a(z_alu_a), .alu_b(z_alu_b), .alu_opn(z_alu_opn),
        .alu_out0(z_alu_out0), .alu_out1(z_alu_out1), .alu_status(z_alu_status),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_out0(z_rsp_out0), .rsp_out1(z_rsp_out1),
        .rsp_status(z_rsp_status), .rsp_tag(z_rsp_tag), .busy(z_busy), .ops_done(z_ops_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic [1:0] tag);
        cmd_a = a; cmd_b = b; cmd_opn = op; cmd_tag = tag; cmd_valid = 1'b1;
    endtask

    task automatic drain(input int budget, output bit idle);
        int n;
        n = 0;
        while (busy && n < budget) begin tick(); n++; end
        idle = !busy;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(4'h9, 4'h9, 3'd1, 2'd1);
        tick(); tick();
        n_cmp++; if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin n_err++;
            $display("FAIL reset_ctrl got rdy/busy/vld=%b want 100", {cmd_ready, busy, rsp_valid}); end
        n_cmp++; if ({alu_a, alu_b, alu_opn, ops_done} !== 19'h0) begin n_err++;
            $display("FAIL reset_regs got alu=%h/%h/%h ops=%0d want zeros", alu_a, alu_b, alu_opn, ops_done); end
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if ({busy, cmd_ready, z_busy} !== 3'b010) begin n_err++;
            $display("FAIL reset_release got busy/rdy/zbusy=%b want 010", {busy, cmd_ready, z_busy}); end
    endtask

    task automatic test_single;
        log_q.delete();
        rsp_ready = 1'b1;
        drive(4'h3, 4'h7, 3'd0, 2'd2);
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_cmp++; if ({alu_a, alu_b, alu_opn, rsp_valid} !== {4'h3, 4'h7, 3'd0, 1'b0}) begin n_err++;
                $display("FAIL single_issue cyc%0d got a=%h b=%h op=%h vld=%b want 3 7 0 0", i, alu_a, alu_b, alu_opn, rsp_valid); end
        end
        tick();
        n_cmp++; if ({rsp_valid, rsp_out0, rsp_out1, rsp_status, rsp_tag} !== {1'b1, 4'hA, 4'h0, 4'h0, 2'd2}) begin n_err++;
            $display("FAIL single_rsp got vld=%b o0=%h o1=%h st=%h tag=%0d want 1 a 0 0 2", rsp_valid, rsp_out0, rsp_out1, rsp_status, rsp_tag); end
        tick();
        n_cmp++; if ({rsp_valid, ops_done} !== {1'b0, 8'd1}) begin n_err++;
            $display("FAIL single_done got vld=%b ops=%0d want 0 1", rsp_valid, ops_done); end
    endtask

    task automatic test_fifo_full;
        logic [3:0]  ta [5] = '{4'h1, 4'h4, 4'h9, 4'hF, 4'hC};
        logic [3:0]  tb [5] = '{4'h2, 4'h5, 4'h3, 4'h1, 4'hA};
        logic [2:0]  top[5] = '{3'd0, 3'd3, 3'd1, 3'd0, 3'd2};
        logic [1:0]  tt [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [13:0] exp[5] = '{{2'd0, 4'h3, 4'h0, 4'h0}, {2'd1, 4'h4, 4'h1, 4'h7},
                                {2'd2, 4'h6, 4'h0, 4'h1}, {2'd3, 4'h0, 4'h1, 4'hC},
                                {2'd0, 4'h8, 4'hE, 4'h6}};
        bit idle;
        log_q.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(ta[i], tb[i], top[i], tt[i]);
            n_cmp++; if (cmd_ready !== 1'b1) begin n_err++;
                $display("FAIL full_accept%0d got rdy=%b want 1", i, cmd_ready); end
            tick();
        end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++;
            $display("FAIL full_ready_low got rdy=%b want 0", cmd_ready); end
        drive(4'hF, 4'hF, 3'd0, 2'd1);
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++;
            $display("FAIL full_no_pop_credit got rdy=%b want 1", cmd_ready); end
        drain(200, idle);
        n_cmp++; if (!idle || log_q.size() != 5) begin n_err++;
            $display("FAIL full_rsp_count got %0d idle=%b want 5 1", log_q.size(), idle); end
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            n_cmp++; if (log_q[i] !== exp[i]) begin n_err++;
                $display("FAIL full_rsp%0d got %h want %h", i, log_q[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] ops0;
        int n;
        bit idle;
        log_q.delete();
        rsp_ready = 1'b0;
        ops0 = ops_done;
        drive(4'h2, 4'h3, 3'd0, 2'd3);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin tick(); n++; end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++;
            $display("FAIL bp_rsp_timeout got vld=%b want 1", rsp_valid); end
        for (int i = 0; i < 10; i++) begin
            drive((i < 4) ? 4'h1 : 4'h7, 4'h1, 3'd0, i[1:0]);
            tick();
            n_cmp++; if ({rsp_valid, rsp_out0, rsp_out1, rsp_status, rsp_tag, alu_a, alu_b, alu_opn}
                         !== {1'b1, 4'h5, 4'h0, 4'h0, 2'd3, 4'h2, 4'h3, 3'd0}) begin n_err++;
                $display("FAIL bp_hold cyc%0d got vld=%b o0=%h tag=%0d alu_a=%h want 1 5 3 2", i, rsp_valid, rsp_out0, rsp_tag, alu_a); end
        end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++;
            $display("FAIL bp_full got rdy=%b want 0", cmd_ready); end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        n_cmp++; if ({rsp_valid, ops_done} !== {1'b0, ops0 + 8'd1}) begin n_err++;
            $display("FAIL bp_release got vld=%b ops=%0d want 0 %0d", rsp_valid, ops_done, ops0 + 8'd1); end
        drain(200, idle);
        n_cmp++; if (!idle || log_q.size() != 5 || ops_done !== ops0 + 8'd5) begin n_err++;
            $display("FAIL bp_drain got n=%0d ops=%0d want 5 %0d", log_q.size(), ops_done, ops0 + 8'd5); end
        for (int i = 1; i < 5 && i < log_q.size(); i++) begin
            n_cmp++; if (log_q[i] !== {2'(i - 1), 4'h2, 4'h0, 4'h0}) begin n_err++;
                $display("FAIL bp_rsp%0d got %h want %h", i, log_q[i], {2'(i - 1), 4'h2, 4'h0, 4'h0}); end
        end
    endtask

    task automatic test_reset_midop;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) rsp_ready = 1'b1;
            drive(4'(i + 1), 4'h1, 3'd0, i[1:0]);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        n_cmp++; if ({busy, rsp_valid, alu_a} !== {1'b1, 1'b0, 4'h2}) begin n_err++;
            $display("FAIL midop_pre got busy=%b vld=%b alu_a=%h want 1 0 2", busy, rsp_valid, alu_a); end
        rst = 1'b0;
        #1;
        log_q.delete();
        n_cmp++; if ({rsp_valid, busy, cmd_ready, ops_done, alu_a} !== {1'b0, 1'b0, 1'b1, 8'd0, 4'h0}) begin n_err++;
            $display("FAIL midop_async got vld=%b busy=%b rdy=%b ops=%0d alu_a=%h want 0 0 1 0 0", rsp_valid, busy, cmd_ready, ops_done, alu_a); end
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (log_q.size() != 0 || {busy, rsp_valid, ops_done} !== 10'h0) begin n_err++;
            $display("FAIL midop_after got n=%0d busy=%b vld=%b ops=%0d want 0 0 0 0", log_q.size(), busy, rsp_valid, ops_done); end
    endtask

    task automatic test_wrap;
        int pushed, cyc;
        bit idle;
        log_q.delete();
        rsp_ready = 1'b1;
        pushed = 0;
        cyc = 0;
        while (pushed < 256 && cyc < 3000) begin
            drive(pushed[3:0], pushed[7:4], pushed[2:0], pushed[1:0]);
            if (cmd_ready) pushed++;
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        drain(100, idle);
        n_cmp++; if (!idle || log_q.size() != 256 || ops_done !== 8'd0) begin n_err++;
            $display("FAIL wrap got n=%0d ops=%0d idle=%b want 256 0 1", log_q.size(), ops_done, idle); end
    endtask

    task automatic test_lat0;
        z_rsp_ready = 1'b1;
        z_cmd_a = 4'h6; z_cmd_b = 4'h2; z_cmd_opn = 3'd1; z_cmd_tag = 2'd1; z_cmd_valid = 1'b1;
        tick();
        z_cmd_valid = 1'b0;
        tick();
        n_cmp++; if ({z_rsp_valid, z_alu_a, z_busy} !== {1'b0, 4'h6, 1'b1}) begin n_err++;
            $display("FAIL lat0_issue got vld=%b alu_a=%h busy=%b want 0 6 1", z_rsp_valid, z_alu_a, z_busy); end
        tick();
        n_cmp++; if ({z_rsp_valid, z_rsp_out0, z_rsp_out1, z_rsp_status, z_rsp_tag} !== {1'b1, 4'h4, 4'h0, 4'h1, 2'd1}) begin n_err++;
            $display("FAIL lat0_rsp got vld=%b o0=%h o1=%h st=%h tag=%0d want 1 4 0 1 1", z_rsp_valid, z_rsp_out0, z_rsp_out1, z_rsp_status, z_rsp_tag); end
        tick();
        n_cmp++; if ({z_rsp_valid, z_ops_done} !== {1'b0, 8'd1}) begin n_err++;
            $display("FAIL lat0_done got vld=%b ops=%0d want 0 1", z_rsp_valid, z_ops_done); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_opn = '0; cmd_tag = '0; rsp_ready = 1'b0;
        z_cmd_valid = 1'b0; z_cmd_a = '0; z_cmd_b = '0; z_cmd_opn = '0; z_cmd_tag = '0; z_rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_fifo_full();
        test_backpressure();
        test_reset_midop();
        test_wrap();
        test_lat0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Front-end controller for the 4-bit ALU (operands a/b, 3-bit opn; results alu_out0, alu_out1, status).
- Accepts tagged ALU commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU and waits its fixed latency.
- Returns captured results with the command tag over a valid/ready response interface.

Parameters:
- ALU_LAT, 1, number of clock edges between ALU input change and valid ALU outputs (0 = combinational ALU).
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command this cycle.
- cmd_a  input  4  operand a.
- cmd_b  input  4  operand b.
- cmd_opn  input  3  ALU opcode, passed through undecoded.
- cmd_tag  input  2  requester tag, returned with result.
- alu_a  output  4  to ALU a.
- alu_b  output  4  to ALU b.
- alu_opn  output  3  to ALU opn.
- alu_out0  input  4  from ALU.
- alu_out1  input  4  from ALU.
- alu_status  input  4  from ALU status.
- rsp_valid  output  1  result held.
- rsp_ready  input  1  consumer accepts result.
- rsp_out0  output  4  captured alu_out0.
- rsp_out1  output  4  captured alu_out1.
- rsp_status  output  4  captured status.
- rsp_tag  output  2  tag of completed command.
- busy  output  1  FIFO non-empty or FSM not IDLE.
- ops_done  output  8  count of completed response handshakes, wraps 255->0.

Behaviour:
- Reset (rst=0, async): FIFO emptied; FSM=IDLE; all registered outputs 0 (alu_*, rsp_*, ops_done). cmd_ready=1 and busy=0 while in reset.
- cmd_ready = (fifo_count < FIFO_DEPTH), combinational from registered count only. No same-cycle pop credit: a full FIFO deasserts cmd_ready even when a pop occurs that cycle.
- Push on cmd_valid&&cmd_ready. Simultaneous push and pop: count unchanged, both take effect. Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop head on the edge; load alu_a/alu_b/alu_opn and the held tag; set wait counter; go WAIT. Otherwise stay; alu_* hold their last value.
  - WAIT: lasts exactly ALU_LAT+1 cycles; alu_* stable throughout. On the final edge, capture alu_out0/alu_out1/alu_status into rsp_out0/rsp_out1/rsp_status, drive rsp_tag, set rsp_valid=1, go RESP.
  - RESP: hold all rsp_* stable while rsp_ready=0. On rsp_valid&&rsp_ready: rsp_valid<=0, ops_done<=ops_done+1, go IDLE. rsp_* data keep their last value.
- Latency: command accepted at edge E into an empty, idle block -> popped at E+1 -> rsp_valid high after edge E+ALU_LAT+2 (E+3 for default).
- Throughput: one command per ALU_LAT+3 cycles at best (IDLE, WAIT, RESP each take ≥1 cycle).
- Commands complete in FIFO order; tags are not reordered.
- Reset asserted mid-operation: in-flight command and queued commands discarded, no response produced, outputs return to reset values immediately.
- The input rsp_ready is ignored outside RESP.

Test Plan:
- Reset: rst=0 for 2 cycles with cmd_valid=1 -> cmd_ready=1, busy=0, rsp_valid=0, alu_a/b/opn=0, ops_done=0, FIFO empty after release.
- Single op, ALU_LAT=1, bench ALU model, rsp_ready=1: cmd a=3 b=7 opn=0 tag=2 -> alu_a=3, alu_b=7, alu_opn=0 for 2 cycles. rsp_valid rises 3 edges after accept with rsp_out0/out1/status equal to the model's outputs for (3,7,0), rsp_tag=2. ops_done=1.
- FIFO full: 5 back-to-back cmd_valid cycles while the first op is waiting (tags 0,1,2,3,0) -> cmd_ready drops after the FIFO holds 4 entries. Responses arrive in push order with matching tags; second op (a=4 b=5 opn=3) returns the model result for opn 3.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and all rsp_* stable, no new issue to the ALU, FIFO accepts until full. Release -> single handshake, ops_done increments by 1.
- Reset mid-op: assert rst=0 during WAIT with 3 entries queued -> immediately rsp_valid=0, busy=0, no response after release, ops_done unchanged at 0 if none completed.
- Wrap: complete 256 ops -> ops_done reads 0. ALU_LAT=0 build: rsp_valid 2 edges after accept.
